// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA scan of a 160x120 RGB332 frame RAM with 4x4 pixel replication
// Optional feature macro: VGA_TEST_PATTERN_EN (colour bars on visible pixels while the latched enable is low)
module vga_frame_reader #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int IMG_W     = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_data,
  input  logic        display_enable,
  output logic [14:0] read_addr,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DW       = $clog2(CLK_DIV);
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v;
  logic [VW-1:0] v_next;
  logic          tick;
  logic          line_end;
  logic          frame_end;
  logic          vis_cur;
  logic          vis_next;
  logic          hsync_cur;
  logic          vsync_cur;
  logic [14:0]   addr_next;
  logic [2:0]    red_cur;
  logic [2:0]    green_cur;
  logic [1:0]    blue_cur;
  logic          en_lat;

  assign tick      = (div == DW'(CLK_DIV - 1));
  assign line_end  = (h == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v == VW'(V_TOTAL - 1));

  // Position the scan moves to on the coming tick
  always_comb begin
    h_next = h + 1'b1;
    v_next = v;
    if (line_end) begin
      h_next = '0;
      v_next = (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end
  end

  // RAM address for the new position; each stored pixel covers a 4x4 screen block
  assign vis_next  = (h_next < HW'(H_VISIBLE)) && (v_next < VW'(V_VISIBLE));
  assign addr_next = vis_next ? ((15'(v_next) >> 2) * 15'(IMG_W) + (15'(h_next) >> 2)) : '0;

  // Sync levels for the pixel currently being left
  assign vis_cur   = (h < HW'(H_VISIBLE)) && (v < VW'(V_VISIBLE));
  assign hsync_cur = !((h >= HW'(HS_START)) && (h <= HW'(HS_END)));
  assign vsync_cur = !((v >= VW'(VS_START)) && (v <= VW'(VS_END)));

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;
  logic [2:0] bar_idx;
  assign bar_idx = 3'(h / HW'(BAR_W));
`endif

  // Colour for the pixel being left: RAM data only when visible and the frame enable is latched
  always_comb begin
    red_cur   = '0;
    green_cur = '0;
    blue_cur  = '0;
    if (vis_cur && en_lat) begin
      red_cur   = pixel_data[7:5];
      green_cur = pixel_data[4:2];
      blue_cur  = pixel_data[1:0];
    end
`ifdef VGA_TEST_PATTERN_EN
    else if (vis_cur) begin
      red_cur   = {3{bar_idx[2]}};
      green_cur = {3{bar_idx[1]}};
      blue_cur  = {2{bar_idx[0]}};
    end
`endif
  end

  // Pixel-clock divider producing one tick every CLK_DIV clocks
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Scan counters, RAM address and the one-tick-delayed sync/colour outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      read_addr   <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      en_lat      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        h         <= h_next;
        v         <= v_next;
        read_addr <= addr_next;
        hsync     <= hsync_cur;
        vsync     <= vsync_cur;
        red       <= red_cur;
        green     <= green_cur;
        blue      <= blue_cur;
        if (frame_end) begin
          en_lat      <= display_enable;
          frame_start <= 1'b1;
        end
      end
    end
  end

endmodule
